// File: rtl/tl45_wb_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tl45_wb_ram
// Purpose  : Wishbone pipelined responder over a word-addressed 32-bit RAM
//            with configurable response latency and out-of-range error.
// Revision : 1.0  initial release
// ============================================================================
module tl45_wb_ram #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 1,
    parameter logic [29:0] BASE_ADDR  = 30'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err,
    output logic [31:0] o_wb_data
);

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] c_LAT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_count;
    logic [2:0]  w_count_next;
    logic [31:0] r_mem [c_DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;

    logic [29:0]           w_offset;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_stall;
    logic                  w_ack;
    logic                  w_accept;
    logic                  w_commit;

    // Offset arithmetic wraps at 30 bits, so addresses below the base land far out of range.
    assign w_offset   = i_wb_addr - BASE_ADDR;
    assign w_idx      = w_offset[ADDR_WIDTH-1:0];
    assign w_in_range = (w_offset[29:ADDR_WIDTH] == '0);

    assign w_stall  = (r_state == S_WAIT);
    assign w_ack    = (r_state == S_RESPOND) && i_wb_cyc;
    assign w_accept = i_wb_cyc && i_wb_stb && !w_stall;
    assign w_commit = w_accept && w_in_range && i_wb_we && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= 3'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_accept) begin
                r_err   <= !w_in_range;
                r_rdata <= (w_in_range && !i_wb_we) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // RAM is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE, S_RESPOND: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_RESPOND;
                    end else begin
                        w_state_next = S_WAIT;
                        w_count_next = c_LAT_LOAD;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                // A dropped cycle wins over the countdown.
                if (!i_wb_cyc) begin
                    w_state_next = S_IDLE;
                end else if (r_count == 3'd1) begin
                    w_state_next = S_RESPOND;
                end else begin
                    w_count_next = r_count - 3'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_wb_stall = w_stall;
    assign o_wb_ack   = w_ack;
    assign o_wb_err   = w_ack && r_err;
    assign o_wb_data  = (w_ack && !r_err) ? r_rdata : 32'd0;

endmodule
`default_nettype wire

// File: doc/tl45_wb_ram.md
Name: tl45_wb_ram

Overview:
- Wishbone pipelined-mode responder (slave) wrapping a word-addressed synchronous RAM.
- Serves instruction fetches from the core prefetch stage and data accesses from the memory stage.
- Latency is configurable. Out-of-range accesses return an error, which initiators treat as retry/fault.
- Stall is generated so that only one request is in flight at a time.

Parameters:
- ADDR_WIDTH, 12, RAM depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from request acceptance to ack. Legal range 1..7.
- BASE_ADDR, 30'h0, word address of RAM word 0. Valid window is [BASE_ADDR, BASE_ADDR + 2**ADDR_WIDTH).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  bus cycle active
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  30  word address
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte enables; bit n covers data[8n+7:8n]
- o_wb_ack  out  1  single-cycle response strobe
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_err  out  1  error response; always paired with o_wb_ack
- o_wb_data  out  32  read data; valid only when ack=1 and err=0

Behaviour:
- Reset (i_reset high at clock edge):
  - state goes to IDLE; latency counter cleared.
  - o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_wb_stall=0.
  - RAM contents are NOT cleared. Reset mid-request drops the request with no ack; a write committed at acceptance stays written.
- Acceptance: a request is accepted on an edge where i_wb_cyc & i_wb_stb & !o_wb_stall. Address, we, sel and data are captured then.
- In range (i_wb_addr - BASE_ADDR < 2**ADDR_WIDTH, unsigned, 30-bit wrap):
  - Write: commits at the acceptance edge. Only bytes with sel=1 change. sel=4'b0000 writes nothing but still acks.
  - Read: RAM word is read at the acceptance edge and held in the response register.
- Out of range: no RAM access. The response is ack=1, err=1, data=0.
- States:
  - IDLE: stall=0, ack=0.
    - Accept with LATENCY==1 -> RESPOND.
    - Accept with LATENCY>1 -> WAIT, counter loaded with LATENCY-1.
  - WAIT: stall=1, ack=0. Counter decrements each cycle; when it reaches 1 -> RESPOND.
  - RESPOND: ack=1 for exactly one cycle. err and data per above. stall=0.
    - A new request may be accepted in this cycle (back-to-back); it follows the IDLE acceptance rules.
    - Otherwise -> IDLE.
- Timing:
  - Ack is asserted exactly LATENCY cycles after the acceptance edge. With LATENCY=1, ack is in the cycle immediately after the strobe cycle.
  - Ack is never asserted in the same cycle as stall, which keeps initiators that qualify ack with !stall correct.
- i_wb_cyc falling in WAIT or RESPOND aborts: next state IDLE, ack/err suppressed from that cycle on. Abort takes priority over the counter.
- o_wb_data returns to 0 in every cycle where ack=0.
- Strobe without cyc is ignored.
- At most one outstanding request; this is guaranteed by stall.

Test Plan:
- Reset then read: preload word 5 = 32'hDEADBEEF, LATENCY=1. Read addr BASE+5 -> ack one cycle after strobe, data=32'hDEADBEEF, err=0, stall never high.
- Byte-select write: write 32'h11223344 with sel=4'b0101 to word 7 (was 32'hAAAAAAAA), then read it back -> 32'hAA22AA44.
- LATENCY=3: read strobe -> stall high for 2 cycles, ack exactly 3 cycles after acceptance, ack and stall never high together.
- Out of range: ADDR_WIDTH=12, read addr BASE+4096 -> ack=1, err=1, data=0. A write to the same address leaves every RAM word unchanged.
- Abort and reset: LATENCY=4, drop cyc one cycle after acceptance -> no ack, next strobe accepted normally. Repeat with i_reset pulsed mid-WAIT -> all outputs 0 next cycle, earlier write data retained.
- Back-to-back: LATENCY=1, strobe in the RESPOND cycle of a read of word 1 -> second ack in the next cycle with word 2 data. Then drive the tl45_prefetch initiator -> fetches addr 0, 4, 8 return the preloaded words in order.
